fractal_sync_1d_initiator: RTL and testbench



---
 rtl/fractal_sync_pkg.sv | 16 +
 rtl/fractal_sync_init_fifo.sv | 52 +++++
 rtl/fractal_sync_1d_initiator.sv | 140 ++++++++++++++
 tb/tb_fractal_sync_1d_initiator.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal-sync initiators: response codes and initiator FSM states.
package fractal_sync_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'b00,
        SYNC_DONE = 2'b01,
        SYNC_ERR  = 2'b10
    } sync_rsp_e;

    typedef enum logic [1:0] {
        INIT_IDLE,
        INIT_ISSUE,
        INIT_STALL
    } sync_init_state_e;

endpackage

// File: rtl/fractal_sync_init_fifo.sv
// Request FIFO for fractal-sync initiators; refuses pushes while full even if a pop coincides.
module fractal_sync_init_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: only pointers and count decide what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/fractal_sync_1d_initiator.sv
// Initiator for one 1D fractal-sync RF port: queues barrier requests, strobes the RF, classifies replies.
// Optional saturating response statistics are enabled with FRACTAL_SYNC_INIT_STATS_EN.
module fractal_sync_1d_initiator
    import fractal_sync_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int DEPTH      = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    output logic [ID_WIDTH-1:0]   id_o,
    output logic                  check_o,
    input  logic                  present_i,
    input  logic                  id_err_i,
    input  logic                  bypass_i,
    input  logic                  ignore_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_WIDTH-1:0]   rsp_id_o,
    output logic [1:0]            rsp_code_o,
    output logic [STAT_WIDTH-1:0] stat_done_o,
    output logic [STAT_WIDTH-1:0] stat_wait_o,
    output logic [STAT_WIDTH-1:0] stat_err_o
);

    function automatic sync_rsp_e classify(input logic id_err, input logic bypass,
                                           input logic ignore, input logic present);
        if (id_err)               return SYNC_ERR;
        else if (bypass | ignore) return SYNC_DONE;
        else if (present)         return SYNC_DONE;
        else                      return SYNC_WAIT;
    endfunction

    logic                  w_full;
    logic                  w_empty;
    logic [ID_WIDTH-1:0]   w_head;
    logic                  w_issue;
    sync_rsp_e             w_code;
    sync_init_state_e      w_state;
    logic                  r_rsp_valid;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    sync_rsp_e             r_rsp_code;

    fractal_sync_init_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ID_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_valid_i),
        .pop_i   (w_issue),
        .data_i  (req_id_i),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    assign req_ready_o = ~w_full;
    assign w_code      = classify(id_err_i, bypass_i, ignore_i, present_i);

    // State follows the live FIFO/response-slot condition, so a draining slot issues in the same cycle.
    always_comb begin
        w_state = INIT_IDLE;
        if (!w_empty) begin
            if (!r_rsp_valid || rsp_ready_i) w_state = INIT_ISSUE;
            else                             w_state = INIT_STALL;
        end
    end

    always_comb begin
        check_o = 1'b0;
        id_o    = '0;
        w_issue = 1'b0;
        case (w_state)
            INIT_ISSUE: begin
                check_o = 1'b1;
                id_o    = w_head;
                w_issue = 1'b1;
            end
            INIT_STALL: id_o = w_head;
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_code  <= SYNC_WAIT;
        end else if (w_issue) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_head;
            r_rsp_code  <= w_code;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_code_o  = r_rsp_code;

`ifdef FRACTAL_SYNC_INIT_STATS_EN
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [STAT_WIDTH-1:0] r_stat_done;
    logic [STAT_WIDTH-1:0] r_stat_wait;
    logic [STAT_WIDTH-1:0] r_stat_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_done <= '0;
            r_stat_wait <= '0;
            r_stat_err  <= '0;
        end else if (w_issue) begin
            case (w_code)
                SYNC_DONE: r_stat_done <= sat_inc(r_stat_done);
                SYNC_WAIT: r_stat_wait <= sat_inc(r_stat_wait);
                SYNC_ERR:  r_stat_err  <= sat_inc(r_stat_err);
                default:   ;
            endcase
        end
    end

    assign stat_done_o = r_stat_done;
    assign stat_wait_o = r_stat_wait;
    assign stat_err_o  = r_stat_err;
`else
    assign stat_done_o = '0;
    assign stat_wait_o = '0;
    assign stat_err_o  = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_1d_initiator.sv
// Self-checking bench for fractal_sync_1d_initiator with a small RF model and a request-order scoreboard.
module tb_fractal_sync_1d_initiator;

    localparam int IDW   = 3;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [IDW-1:0] req_id_i;
    logic [IDW-1:0] id_o;
    logic           check_o;
    logic           present_i;
    logic           id_err_i;
    logic           bypass_i;
    logic           ignore_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [IDW-1:0] rsp_id_o;
    logic [1:0]     rsp_code_o;
    logic [SW-1:0]  stat_done_o;
    logic [SW-1:0]  stat_wait_o;
    logic [SW-1:0]  stat_err_o;

    logic rf_mode, rf_clr, tb_present, tb_id_err, tb_bypass, tb_ignore;
    logic [7:0] rf;
    logic [7:0] model_rf;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fractal_sync_1d_initiator #(
        .ID_WIDTH   (IDW),
        .DEPTH      (DEPTH),
        .STAT_WIDTH (SW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_id_i    (req_id_i),
        .id_o        (id_o),
        .check_o     (check_o),
        .present_i   (present_i),
        .id_err_i    (id_err_i),
        .bypass_i    (bypass_i),
        .ignore_i    (ignore_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_code_o  (rsp_code_o),
        .stat_done_o (stat_done_o),
        .stat_wait_o (stat_wait_o),
        .stat_err_o  (stat_err_o)
    );

    // RF environment: in rf_mode, id 7 is out of range and id 6 is bypassed.
    assign present_i = rf_mode ? rf[id_o] : tb_present;
    assign id_err_i  = rf_mode ? (id_o == 3'd7) : tb_id_err;
    assign bypass_i  = rf_mode ? (id_o == 3'd6) : tb_bypass;
    assign ignore_i  = rf_mode ? 1'b0 : tb_ignore;

    always @(posedge clk) begin
        if (rf_clr) rf <= '0;
        else if (check_o && !id_err_i && !bypass_i && !ignore_i) rf[id_o] <= ~rf[id_o];
    end

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_id_i = '0;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    // Pushes one request and returns at the falling edge of the cycle its response is visible.
    task automatic send_one(input logic [IDW-1:0] id);
        @(posedge clk); #1;
        req_valid_i = 1'b1;
        req_id_i = id;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_id_i = '0; rsp_ready_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (req_ready_o !== 1'b1 || check_o !== 1'b0 || id_o !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b check=%b id=%0d, required 1 0 0", req_ready_o, check_o, id_o);
        end
        n_tests++;
        if (rsp_valid_o !== 1'b0 || rsp_id_o !== '0 || rsp_code_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b id=%0d code=%0d, required 0 0 0", rsp_valid_o, rsp_id_o, rsp_code_o);
        end
        n_tests++;
        if (stat_done_o !== '0 || stat_wait_o !== '0 || stat_err_o !== '0) begin
            n_fail++;
            $display("FAIL reset_stats: %0d %0d %0d, required 0 0 0", stat_done_o, stat_wait_o, stat_err_o);
        end
        do_reset();
    endtask

    task automatic test_single_wait();
        rf_mode = 1'b0; tb_present = 1'b0; tb_id_err = 1'b0; tb_bypass = 1'b0; tb_ignore = 1'b0;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_id_i = 3'd3; rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (check_o !== 1'b1 || id_o !== 3'd3) begin
            n_fail++;
            $display("FAIL single_issue: check=%b id=%0d, required 1 3", check_o, id_o);
        end
        @(negedge clk);
        n_tests++;
        if (check_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_id_o !== 3'd3 || rsp_code_o !== 2'b00) begin
            n_fail++;
            $display("FAIL single_rsp: check=%b valid=%b id=%0d code=%0d, required 0 1 3 0",
                     check_o, rsp_valid_o, rsp_id_o, rsp_code_o);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: valid=%b, required 0", rsp_valid_o);
        end
    endtask

    task automatic test_rf_pair();
        rf_mode = 1'b1;
        @(posedge clk); #1; rf_clr = 1'b1;
        @(posedge clk); #1; rf_clr = 1'b0;
        req_valid_i = 1'b1; req_id_i = 3'd3; rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 3'd3 || rsp_code_o !== 2'b00) begin
            n_fail++;
            $display("FAIL pair_first: valid=%b id=%0d code=%0d, required 1 3 0", rsp_valid_o, rsp_id_o, rsp_code_o);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 3'd3 || rsp_code_o !== 2'b01) begin
            n_fail++;
            $display("FAIL pair_second: valid=%b id=%0d code=%0d, required 1 3 1", rsp_valid_o, rsp_id_o, rsp_code_o);
        end
        @(negedge clk);
        n_tests++;
        if (rf[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_rf_bit: rf[3]=%b, required 0", rf[3]);
        end
        rf_mode = 1'b0;
    endtask

    task automatic test_bypass_err();
        rsp_ready_i = 1'b1;
        tb_bypass = 1'b1; tb_present = 1'($urandom_range(0, 1)); tb_id_err = 1'b0; tb_ignore = 1'b0;
        send_one(3'd5);
        n_tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 3'd5 || rsp_code_o !== 2'b01) begin
            n_fail++;
            $display("FAIL bypass_done: valid=%b id=%0d code=%0d, required 1 5 1", rsp_valid_o, rsp_id_o, rsp_code_o);
        end
        tb_id_err = 1'b1;
        send_one(3'd5);
        n_tests++;
        if (rsp_valid_o !== 1'b1 || rsp_code_o !== 2'b10) begin
            n_fail++;
            $display("FAIL err_priority: valid=%b code=%0d, required 1 2", rsp_valid_o, rsp_code_o);
        end
        tb_id_err = 1'b0; tb_bypass = 1'b0; tb_ignore = 1'b1; tb_present = 1'b0;
        send_one(3'd2);
        n_tests++;
        if (rsp_valid_o !== 1'b1 || rsp_id_o !== 3'd2 || rsp_code_o !== 2'b01) begin
            n_fail++;
            $display("FAIL ignore_done: valid=%b id=%0d code=%0d, required 1 2 1", rsp_valid_o, rsp_id_o, rsp_code_o);
        end
        tb_ignore = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall_backpressure();
        int checks = 0;
        tb_present = 1'b0; tb_id_err = 1'b0; tb_bypass = 1'b0; tb_ignore = 1'b0;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            req_valid_i = 1'b1; req_id_i = IDW'(i);
            @(negedge clk);
            if (check_o) checks++;
            @(posedge clk); #1;
        end
        req_valid_i = 1'b1; req_id_i = 3'd6;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (check_o) checks++;
            n_tests++;
            if (req_ready_o !== 1'b0 || check_o !== 1'b0 || id_o !== 3'd2 || rsp_id_o !== 3'd1) begin
                n_fail++;
                $display("FAIL stall_state: ready=%b check=%b id=%0d rsp_id=%0d, required 0 0 2 1",
                         req_ready_o, check_o, id_o, rsp_id_o);
            end
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        n_tests++;
        if (checks != 1) begin
            n_fail++;
            $display("FAIL stall_single_issue: checks=%0d, required 1", checks);
        end
        rsp_ready_i = 1'b1;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid_o !== 1'b1 || rsp_id_o !== IDW'(i)) begin
                n_fail++;
                $display("FAIL stall_drain_%0d: valid=%b id=%0d, required 1 %0d", i, rsp_valid_o, rsp_id_o, i);
            end
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_empty: valid=%b ready=%b, required 0 1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1; req_id_i = IDW'(i + 1);
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || check_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b ready=%b check=%b, required 0 1 0", rsp_valid_o, req_ready_o, check_o);
        end
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (check_o || rsp_valid_o) seen = 1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_flush: activity after reset=1, required 0");
        end
    endtask

    task automatic test_stats();
        logic [SW-1:0] exp_done, exp_err;
        do_reset();
        tb_bypass = 1'b1; tb_id_err = 1'b0; tb_ignore = 1'b0; tb_present = 1'b0;
        for (int i = 0; i < 5; i++) send_one(IDW'(i));
        tb_id_err = 1'b1;
        send_one(3'd1);
        tb_id_err = 1'b0; tb_bypass = 1'b0;
`ifdef FRACTAL_SYNC_INIT_STATS_EN
        exp_done = 2'd3; exp_err = 2'd1;
`else
        exp_done = 2'd0; exp_err = 2'd0;
`endif
        n_tests++;
        if (stat_done_o !== exp_done || stat_err_o !== exp_err || stat_wait_o !== 2'd0) begin
            n_fail++;
            $display("FAIL stats_sat: done=%0d wait=%0d err=%0d, required %0d 0 %0d",
                     stat_done_o, stat_wait_o, stat_err_o, exp_done, exp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [IDW-1:0] q_id[$];
        logic [1:0]     q_code[$];
        int acc = 0, chk = 0, cnt_done = 0, cnt_wait = 0, cnt_err = 0, bad = 0;
        logic [1:0] code;
        logic [IDW-1:0] eid;
        logic [1:0] ecode;
        logic exp_ready;
        logic [SW-1:0] sd, sw_, se;
        do_reset();
        rf_mode = 1'b1;
        model_rf = '0;
        @(posedge clk); #1; rf_clr = 1'b1;
        @(posedge clk); #1; rf_clr = 1'b0;
        for (int c = 0; c < 460; c++) begin
            req_valid_i = (c < 400) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            req_id_i    = IDW'($urandom_range(0, 7));
            rsp_ready_i = (c < 400) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            exp_ready = ((acc - chk) != DEPTH);
            if (req_ready_o !== exp_ready) begin
                bad++;
                if (bad < 5) $display("FAIL rand_ready: ready=%b, required %b", req_ready_o, exp_ready);
            end
            if (check_o && rsp_valid_o && !rsp_ready_i) begin
                bad++;
                if (bad < 5) $display("FAIL rand_blocked_check: check=1, required 0");
            end
            if (rsp_valid_o && rsp_ready_i) begin
                n_tests++;
                if (q_id.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_rsp_unexpected: id=%0d, required none", rsp_id_o);
                end else begin
                    eid = q_id.pop_front();
                    ecode = q_code.pop_front();
                    if (rsp_id_o !== eid || rsp_code_o !== ecode) begin
                        n_fail++;
                        $display("FAIL rand_rsp: id=%0d code=%0d, required %0d %0d", rsp_id_o, rsp_code_o, eid, ecode);
                    end
                end
            end
            if (req_valid_i && req_ready_o) begin
                if (req_id_i == 3'd7) begin
                    code = 2'b10; cnt_err++;
                end else if (req_id_i == 3'd6) begin
                    code = 2'b01; cnt_done++;
                end else if (model_rf[req_id_i]) begin
                    code = 2'b01; cnt_done++; model_rf[req_id_i] = 1'b0;
                end else begin
                    code = 2'b00; cnt_wait++; model_rf[req_id_i] = 1'b1;
                end
                q_id.push_back(req_id_i);
                q_code.push_back(code);
                acc++;
            end
            if (check_o) chk++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_protocol: violations=%0d, required 0", bad);
        end
        n_tests++;
        if (q_id.size() != 0 || chk != acc) begin
            n_fail++;
            $display("FAIL rand_drain: left=%0d checks=%0d accepts=%0d, required 0 and equal", q_id.size(), chk, acc);
        end
`ifdef FRACTAL_SYNC_INIT_STATS_EN
        sd = SW'((cnt_done > 3) ? 3 : cnt_done);
        sw_ = SW'((cnt_wait > 3) ? 3 : cnt_wait);
        se = SW'((cnt_err > 3) ? 3 : cnt_err);
`else
        sd = '0; sw_ = '0; se = '0;
`endif
        n_tests++;
        if (stat_done_o !== sd || stat_wait_o !== sw_ || stat_err_o !== se) begin
            n_fail++;
            $display("FAIL rand_stats: %0d %0d %0d, required %0d %0d %0d",
                     stat_done_o, stat_wait_o, stat_err_o, sd, sw_, se);
        end
        rf_mode = 1'b0;
    endtask

    initial begin
        rf_mode = 1'b0; rf_clr = 1'b0;
        tb_present = 1'b0; tb_id_err = 1'b0; tb_bypass = 1'b0; tb_ignore = 1'b0;
        test_reset();
        test_single_wait();
        test_rf_pair();
        test_bypass_err();
        test_stall_backpressure();
        test_reset_mid();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
